uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
Consumer stage on the read side of the async FIFO, in the UART TX clock domain. Pops bytes from the FIFO read port and serialises each one as a UART frame: start bit, data LSB first, optional parity, stop bit. Keeps frames back-to-back while the FIFO holds data, and idles the line high otherwise.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH.
CLKS_PER_BIT, 1, CLK cycles per serial bit; must be >= 1.

Ports:
CLK  input  1  TX-domain clock; same clock as the FIFO R_CLK.
RST  input  1  synchronous, active-high reset.
FIFO_EMPTY  input  1  FIFO EMPTY flag.
FIFO_RD_DATA  input  WIDTH  FIFO RD_DATA; valid combinationally whenever FIFO_EMPTY=0 (first-word fall-through).
FIFO_RD_INC  output  1  one-cycle pop strobe, drives the FIFO R_INC.
PAR_EN  input  1  1 = parity bit inserted.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line, idle high.
BUSY  output  1  high from the pop cycle until the last stop-bit cycle of the final frame.

Behaviour:
- Reset values (RST=1 at a CLK edge): TX_OUT=1, BUSY=0, FIFO_RD_INC=0, FSM=IDLE, bit and tick counters=0, shift register=0. RST takes priority over all other conditions.
- FSM states: IDLE, START, DATA, PARITY, STOP. Every non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a tick counter.
- IDLE: TX_OUT=1.
  - If FIFO_EMPTY=0, assert FIFO_RD_INC for exactly that one cycle.
  - In the same cycle, latch FIFO_RD_DATA, PAR_EN and PAR_TYP, set BUSY=1, and go to START.
  - Pop-to-start-bit latency is 1 cycle.
- START: TX_OUT=0. Then DATA.
- DATA: TX_OUT=shift[0]; shift right once per bit. After WIDTH bits, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = XOR of the latched data XOR latched PAR_TYP. Then STOP.
- STOP: TX_OUT=1. On the last cycle of STOP:
  - If FIFO_EMPTY=0: pulse FIFO_RD_INC, latch the new word and config, go straight to START. No idle gap; BUSY stays 1.
  - Else: go to IDLE with BUSY=0 from the next cycle.
- FIFO_RD_INC is never asserted while FIFO_EMPTY=1, and at most once per frame.
- PAR_EN/PAR_TYP changes mid-frame have no effect on the frame in flight.
- Frame length in cycles = CLKS_PER_BIT*(1+WIDTH+PAR_EN+1).
- Reset mid-frame: line returns high on the next edge; the popped word is discarded and not re-read.
- FIFO_EMPTY deasserting during a frame has no effect until the last STOP cycle.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP lasts 2*CLKS_PER_BIT cycles (two stop bits). Back-to-back pop occurs on the last cycle of the second stop bit. Frame length increases by CLKS_PER_BIT.
- Undefined: one stop bit, as above.

Test Plan:
- Reset idle: RST=1 for 2 cycles, FIFO_EMPTY=1 -> TX_OUT=1, BUSY=0, FIFO_RD_INC=0 held indefinitely.
- Single byte, no parity: CLKS_PER_BIT=1, FIFO_RD_DATA=0xA5, FIFO_EMPTY falls for one pop -> one FIFO_RD_INC pulse; TX_OUT from the next cycle = 0,1,0,1,0,0,1,0,1,1; BUSY low after 11 cycles total.
- Parity: PAR_EN=1, PAR_TYP=0, data 0x07 -> parity bit 1; PAR_TYP=1 -> parity bit 0; frame 11 bits.
- Back-to-back: FIFO holds 0x01, 0x02, 0x03, FIFO_EMPTY=0 throughout -> 3 pops spaced exactly 10 cycles apart; no idle-high gap between frames; BUSY high continuously; goes to IDLE after the third stop bit.
- Prescale: CLKS_PER_BIT=4, data 0xFF -> each bit held 4 cycles; start bit low for 4 cycles; frame 40 cycles.
- Reset mid-frame: assert RST during the DATA state at bit 3 -> TX_OUT=1 and BUSY=0 on the next edge; no extra FIFO_RD_INC; the next frame starts cleanly from IDLE.

Source files
------------

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-port bundle between the async FIFO (master side) and the UART TX drain (slave side).
// First-word fall-through: FIFO_RD_DATA is valid whenever FIFO_EMPTY is low.
interface uart_tx_fifo_drain_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             FIFO_EMPTY;
    logic [WIDTH-1:0] FIFO_RD_DATA;
    logic             FIFO_RD_INC;

    modport master (
        output FIFO_EMPTY,
        output FIFO_RD_DATA,
        input  FIFO_RD_INC
    );

    modport slave (
        input  FIFO_EMPTY,
        input  FIFO_RD_DATA,
        output FIFO_RD_INC
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART TX drain: pops words from a FWFT FIFO and serialises them as start/data/parity/stop frames.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx_fifo_drain #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    uart_tx_fifo_drain_if.slave        fifo,
    input  logic                       PAR_EN,
    input  logic                       PAR_TYP,
    output logic                       TX_OUT,
    output logic                       BUSY
);

`ifdef UART_TX_TWO_STOP_EN
    localparam int unsigned STOP_TICKS = 2 * CLKS_PER_BIT;
`else
    localparam int unsigned STOP_TICKS = CLKS_PER_BIT;
`endif
    localparam int unsigned TICK_W = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
    localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [TICK_W-1:0]  r_tick;
    logic [BIT_W-1:0]   r_bit;
    logic [WIDTH-1:0]   r_shift;
    logic               r_par_en;
    logic               r_par_bit;
    logic               r_tx;
    logic               r_busy;

    logic               w_tick_last;
    logic               w_stop_last;
    logic               w_bit_last;
    logic               w_pop;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_par_nxt;

    assign w_tick_last = (r_tick == TICK_W'(CLKS_PER_BIT - 1));
    assign w_stop_last = (r_tick == TICK_W'(STOP_TICKS - 1));
    assign w_bit_last  = (r_bit == BIT_W'(WIDTH - 1));
    assign w_shift_nxt = r_shift >> 1;
    assign w_par_nxt   = (^fifo.FIFO_RD_DATA) ^ PAR_TYP;

    // Pop strobe is combinational so the FIFO advances on the same edge that latches the word.
    assign w_pop = !RST && !fifo.FIFO_EMPTY &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_last));

    assign fifo.FIFO_RD_INC = w_pop;
    assign TX_OUT           = r_tx;
    assign BUSY             = r_busy;

    // Frame sequencer; r_tx is loaded with the level of the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_pop) begin
            r_state   <= S_START;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= fifo.FIFO_RD_DATA;
            r_par_en  <= PAR_EN;
            r_par_bit <= w_par_nxt;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end

                S_START: begin
                    if (w_tick_last) begin
                        r_state <= S_DATA;
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_tick <= TICK_W'(r_tick + 1'b1);
                    end
                end

                S_DATA: begin
                    if (w_tick_last) begin
                        r_tick  <= '0;
                        r_shift <= w_shift_nxt;
                        if (w_bit_last) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit <= BIT_W'(r_bit + 1'b1);
                            r_tx  <= w_shift_nxt[0];
                        end
                    end else begin
                        r_tick <= TICK_W'(r_tick + 1'b1);
                    end
                end

                S_PARITY: begin
                    if (w_tick_last) begin
                        r_state <= S_STOP;
                        r_tick  <= '0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_tick <= TICK_W'(r_tick + 1'b1);
                    end
                end

                S_STOP: begin
                    // A non-empty FIFO on the last stop cycle is taken by the w_pop branch.
                    if (w_stop_last) begin
                        r_state <= S_IDLE;
                        r_tick  <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tick <= TICK_W'(r_tick + 1'b1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: one DUT at 1 clk/bit, one at 4 clk/bit, each fed by a small FWFT FIFO model.
module tb_uart_tx_fifo_drain;

    logic CLK = 1'b0;
    logic RST;
    logic PAR_EN;
    logic PAR_TYP;
    logic tx1, busy1, tx4, busy4;

    always #5 CLK = ~CLK;

    uart_tx_fifo_drain_if #(.WIDTH(8)) if1 ();
    uart_tx_fifo_drain_if #(.WIDTH(8)) if4 ();

    uart_tx_fifo_drain #(.WIDTH(8), .CLKS_PER_BIT(1)) u1 (
        .CLK(CLK), .RST(RST), .fifo(if1.slave),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx1), .BUSY(busy1)
    );

    uart_tx_fifo_drain #(.WIDTH(8), .CLKS_PER_BIT(4)) u4 (
        .CLK(CLK), .RST(RST), .fifo(if4.slave),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx4), .BUSY(busy4)
    );

    // FIFO models: the bench pushes with blocking writes, pops follow RD_INC at the clock edge
    logic [7:0] mem1 [0:63];
    logic [7:0] mem4 [0:63];
    int wp1 = 0, rp1 = 0, pops1 = 0;
    int wp4 = 0, rp4 = 0, pops4 = 0;
    int cyc = 0;
    int pop_cyc1 [0:63];

    assign if1.FIFO_EMPTY   = (wp1 == rp1);
    assign if1.FIFO_RD_DATA = mem1[rp1];
    assign if4.FIFO_EMPTY   = (wp4 == rp4);
    assign if4.FIFO_RD_DATA = mem4[rp4];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (if1.FIFO_RD_INC) begin
            rp1             <= rp1 + 1;
            pops1           <= pops1 + 1;
            pop_cyc1[pops1] <= cyc;
        end
        if (if4.FIFO_RD_INC) begin
            rp4   <= rp4 + 1;
            pops4 <= pops4 + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wp1] = d;
        wp1++;
    endtask

    // Walk one DUT-1 bit per cycle: TX level, BUSY high, and the expected pop strobe
    task automatic frame1(input string tag, input string bits, input string incs);
        for (int i = 0; i < bits.len(); i++) begin
            step();
            chk($sformatf("%s_tx%0d", tag, i), 32'(tx1), 32'(bits[i] == "1"));
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy1), 32'd1);
            chk($sformatf("%s_inc%0d", tag, i), 32'(if1.FIFO_RD_INC), 32'(incs[i] == "1"));
        end
    endtask

    int p0;
    string s_bits, s_incs;

    initial begin
        RST     = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        step();
        chk("rst_tx1",   32'(tx1),   32'd1);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_inc1",  32'(if1.FIFO_RD_INC), 32'd0);
        chk("rst_tx4",   32'(tx4),   32'd1);
        chk("rst_busy4", 32'(busy4), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("idle_tx%0d", i),   32'(tx1),   32'd1);
            chk($sformatf("idle_busy%0d", i), 32'(busy1), 32'd0);
            chk($sformatf("idle_inc%0d", i),  32'(if1.FIFO_RD_INC), 32'd0);
        end

        // Single byte 0xA5, no parity
        push1(8'hA5);
        #1;
        chk("a5_pop", 32'(if1.FIFO_RD_INC), 32'd1);
        frame1("a5", "0101001011", "0000000000");
        step();
        chk("a5_done_busy", 32'(busy1), 32'd0);
        chk("a5_done_tx",   32'(tx1),   32'd1);
        chk("a5_pops",      32'(pops1), 32'd1);

        // Even parity on 0x07 -> parity bit 1
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        push1(8'h07);
        frame1("par_even", "01110000011", "00000000000");
        step();
        chk("par_even_done", 32'(busy1), 32'd0);

        // Odd parity on 0x07 -> parity bit 0; config changed mid-frame must not matter
        PAR_TYP = 1'b1;
        push1(8'h07);
        step();
        chk("par_odd_start", 32'(tx1), 32'd0);
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        frame1("par_odd", "1110000001", "0000000000");
        step();
        chk("par_odd_done", 32'(busy1), 32'd0);

        // Back-to-back 0x01, 0x02, 0x03
        p0 = pops1;
        push1(8'h01);
        push1(8'h02);
        push1(8'h03);
        #1;
        chk("b2b_pop0", 32'(if1.FIFO_RD_INC), 32'd1);
        s_bits = {"0100000001", "0010000001", "0110000001"};
        s_incs = {"0000000001", "0000000001", "0000000000"};
        frame1("b2b", s_bits, s_incs);
        step();
        chk("b2b_done_busy", 32'(busy1), 32'd0);
        chk("b2b_done_tx",   32'(tx1),   32'd1);
        chk("b2b_pops",      32'(pops1 - p0), 32'd3);
        chk("b2b_gap01", 32'(pop_cyc1[p0 + 1] - pop_cyc1[p0]),     32'd10);
        chk("b2b_gap12", 32'(pop_cyc1[p0 + 2] - pop_cyc1[p0 + 1]), 32'd10);

        // Prescale 4 on 0xFF: start low 4 cycles, 40-cycle frame
        mem4[wp4] = 8'hFF;
        wp4++;
        #1;
        chk("pre_pop", 32'(if4.FIFO_RD_INC), 32'd1);
        for (int i = 0; i < 40; i++) begin
            step();
            chk($sformatf("pre_tx%0d", i),   32'(tx4),   (i < 4) ? 32'd0 : 32'd1);
            chk($sformatf("pre_busy%0d", i), 32'(busy4), 32'd1);
        end
        step();
        chk("pre_done_busy", 32'(busy4), 32'd0);
        chk("pre_pops",      32'(pops4), 32'd1);

        // Reset during data bit 3, with another word already waiting
        p0 = pops1;
        push1(8'hA5);
        frame1("rst_pre", "01010", "00000");
        RST = 1'b1;
        push1(8'h3C);
        #1;
        chk("rst_mid_inc_gated", 32'(if1.FIFO_RD_INC), 32'd0);
        step();
        chk("rst_mid_tx",   32'(tx1),   32'd1);
        chk("rst_mid_busy", 32'(busy1), 32'd0);
        chk("rst_mid_inc",  32'(if1.FIFO_RD_INC), 32'd0);
        chk("rst_mid_pops", 32'(pops1 - p0), 32'd1);
        RST = 1'b0;
        #1;
        chk("rst_post_pop", 32'(if1.FIFO_RD_INC), 32'd1);
        frame1("rst_post", "0001111001", "0000000000");
        step();
        chk("rst_post_done", 32'(busy1), 32'd0);
        chk("rst_post_pops", 32'(pops1 - p0), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
